grf_wb_arbiter: RTL
===================

// Module: grf_wb_arbiter
// PURPOSE
//  Write-side front end of the GRF. Merges two result producers onto the single GRF write port:
//  - in-order pipeline W stage: has priority, never stalls;
//  - multi-cycle MDU results: buffered in a small FIFO, drained on cycles the W stage does not write.
//  Keeps a per-register pending (busy) scoreboard so D-stage stall logic can block readers of
//  registers with a reserved but undrained MDU result.
// PARAMETERS
//  DEPTH  4  MDU result FIFO entries (power of two, >=2)
//  AW     2  log2(DEPTH); pointer width
// PORTS
//  clk        in   1   clock, rising edge
//  reset      in   1   synchronous, active-high
//  wb_we      in   1   W-stage write request (always accepted)
//  wb_addr    in   5   W-stage destination register
//  wb_data    in   32  W-stage write data
//  wb_pc      in   32  W-stage instruction PC (for GRF write log)
//  rsv_valid  in   1   D-stage issues an MDU op; reserves rsv_addr
//  rsv_addr   in   5   register to reserve
//  mdu_valid  in   1   MDU result offered
//  mdu_ready  out  1   FIFO can accept (= !full)
//  mdu_addr   in   5   MDU result destination
//  mdu_data   in   32  MDU result data
//  mdu_pc     in   32  PC of the MDU instruction
//  qa_addr    in   5   scoreboard query A (rs)
//  qb_addr    in   5   scoreboard query B (rt)
//  qa_busy    out  1   busy[qa_addr], combinational
//  qb_busy    out  1   busy[qb_addr], combinational
//  grf_we     out  1   GRF write enable
//  grf_addr   out  5   GRF write address
//  grf_data   out  32  GRF write data
//  grf_pc     out  32  PC passed to GRF
//  fifo_cnt   out  AW+1  occupancy 0..DEPTH
// BEHAVIOUR
//  - Reset: FIFO empty (rd/wr ptr 0, fifo_cnt 0), busy[31:0]=0, mdu_ready=1; grf_we forced 0 while reset=1.
//  - Write port (combinational):
//    - wb_we && wb_addr!=0 -> drive W-stage fields;
//    - else FIFO non-empty -> drive FIFO head, pop at next edge;
//    - else grf_we=0, other outputs 0.
//  - W-stage write with wb_addr==0: not forwarded; the FIFO head may use the port that cycle.
//  - Push: mdu_valid && mdu_ready at edge stores {addr,data,pc} at wr ptr.
//    - mdu_addr==0: handshake completes, nothing stored.
//  - mdu_ready = (fifo_cnt!=DEPTH); no same-cycle pop bypass into a full FIFO.
//  - Pointers wrap modulo DEPTH.
//  - Push+pop same edge: fifo_cnt unchanged.
//  - Pushed entry reaches the GRF no earlier than the next cycle (min latency 1).
//  - FIFO drain is strictly in order.
//  - Scoreboard:
//    - rsv_valid && rsv_addr!=0 sets busy[rsv_addr] at edge;
//    - a pop of entry with addr r clears busy[r] at edge;
//    - set and clear of same r on same edge: set wins;
//    - busy[0] is constant 0;
//    - queries read registered busy: a reservation made this cycle is visible next cycle.
//  - Upstream contract: at most one outstanding reservation per register; D stalls on busy (RAW and WAW).
//    - W-stage write to a busy register is an upstream error: still written, busy unchanged.
//  - Reset mid-operation: queued entries discarded, not written; all busy cleared.
// TESTING
//  - Reset with 3 entries queued and busy[5]=1 -> fifo_cnt=0, busy all 0, grf_we=0, mdu_ready=1.
//  - rsv $5; next cycle push {5,0x1234,0x3010} with wb_we=0 -> qa_busy(5)=1;
//    next cycle grf_we=1,addr=5,data=0x1234; following cycle qa_busy=0.
//  - Push 4 entries ($8..$11) while wb_we=1 every cycle -> no pops; mdu_ready=0 after 4th.
//    Release wb_we -> writes $8,$9,$10,$11 in 4 consecutive cycles; mdu_ready returns 1 after first pop.
//  - Full FIFO, mdu_valid=1, pop same edge -> that edge no push; fifo_cnt 4->3; push on next edge.
//  - Push mdu_addr=0 -> accepted, fifo_cnt stays 0, no GRF write.
//    wb_we=1,wb_addr=0 with FIFO head valid -> head written that cycle.
//  - Reserve $7 on the same edge $7's entry pops -> busy[7]=1 after edge.
//    Check pointer wrap over 10 push/pop cycles -> data order preserved.

Source files
------------

// File: rtl/grf_wb_arbiter.sv
// GRF write-side arbiter: the W stage has priority on the single write port; MDU results queue in a
// small FIFO and drain on idle W cycles, with a per-register pending scoreboard for D-stage stalls.
module grf_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wb_we,
  input  logic [4:0]    wb_addr,
  input  logic [31:0]   wb_data,
  input  logic [31:0]   wb_pc,
  input  logic          rsv_valid,
  input  logic [4:0]    rsv_addr,
  input  logic          mdu_valid,
  output logic          mdu_ready,
  input  logic [4:0]    mdu_addr,
  input  logic [31:0]   mdu_data,
  input  logic [31:0]   mdu_pc,
  input  logic [4:0]    qa_addr,
  input  logic [4:0]    qb_addr,
  output logic          qa_busy,
  output logic          qb_busy,
  output logic          grf_we,
  output logic [4:0]    grf_addr,
  output logic [31:0]   grf_data,
  output logic [31:0]   grf_pc,
  output logic [AW:0]   fifo_cnt
);

  localparam logic [AW:0] FullCnt = (AW+1)'(DEPTH);

  logic [4:0]    addrMem [DEPTH];
  logic [31:0]   dataMem [DEPTH];
  logic [31:0]   pcMem   [DEPTH];
  logic [AW-1:0] wrPtrR;
  logic [AW-1:0] rdPtrR;
  logic [AW:0]   cntR;
  logic [31:0]   busyR;

  logic          wbSelS;
  logic          nonEmptyS;
  logic          popS;
  logic          pushS;
  logic [31:0]   busyNextS;

  assign fifo_cnt  = cntR;
  assign mdu_ready = (cntR != FullCnt);
  assign qa_busy   = busyR[qa_addr];
  assign qb_busy   = busyR[qb_addr];

  // Handshake decode; writes to $0 never occupy the port or the FIFO.
  always_comb begin
    wbSelS    = wb_we && (wb_addr != 5'd0);
    nonEmptyS = (cntR != {(AW+1){1'b0}});
    popS      = !reset && !wbSelS && nonEmptyS;
    pushS     = mdu_valid && mdu_ready && (mdu_addr != 5'd0);
  end

  // Write-port mux: W stage first, then FIFO head, otherwise idle.
  always_comb begin
    grf_we   = 1'b0;
    grf_addr = 5'd0;
    grf_data = 32'd0;
    grf_pc   = 32'd0;
    if (reset) begin
      grf_we = 1'b0;
    end else if (wbSelS) begin
      grf_we   = 1'b1;
      grf_addr = wb_addr;
      grf_data = wb_data;
      grf_pc   = wb_pc;
    end else if (nonEmptyS) begin
      grf_we   = 1'b1;
      grf_addr = addrMem[rdPtrR];
      grf_data = dataMem[rdPtrR];
      grf_pc   = pcMem[rdPtrR];
    end else begin
      grf_we = 1'b0;
    end
  end

  // Scoreboard update: clear on drain, then set on reservation so a same-edge set wins.
  always_comb begin
    busyNextS = busyR;
    if (popS) begin
      busyNextS[addrMem[rdPtrR]] = 1'b0;
    end else begin
      busyNextS = busyNextS;
    end
    if (rsv_valid && (rsv_addr != 5'd0)) begin
      busyNextS[rsv_addr] = 1'b1;
    end else begin
      busyNextS = busyNextS;
    end
    busyNextS[0] = 1'b0;
  end

  // Pointers, occupancy and scoreboard state.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtrR <= {AW{1'b0}};
      rdPtrR <= {AW{1'b0}};
      cntR   <= {(AW+1){1'b0}};
      busyR  <= 32'd0;
    end else begin
      if (pushS) wrPtrR <= wrPtrR + AW'(1);
      if (popS)  rdPtrR <= rdPtrR + AW'(1);
      case ({pushS, popS})
        2'b10:   cntR <= cntR + (AW+1)'(1);
        2'b01:   cntR <= cntR - (AW+1)'(1);
        default: cntR <= cntR;
      endcase
      busyR <= busyNextS;
    end
  end

  // Entry storage; contents are don't-care until pushed, so no reset is needed.
  always_ff @(posedge clk) begin
    if (pushS && !reset) begin
      addrMem[wrPtrR] <= mdu_addr;
      dataMem[wrPtrR] <= mdu_data;
      pcMem[wrPtrR]   <= mdu_pc;
    end
  end

endmodule
